// File: rtl/adder_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/comparator.
// master drives operands and consumes results; slave is the adder itself.
interface adder_serial_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         Nadd_sub;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         eq;
  logic         lt;
  logic         ltu;

  modport master (
    output in_valid, Nadd_sub, X, Y, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, eq, lt, ltu
  );

  modport slave (
    input  in_valid, Nadd_sub, X, Y, out_ready,
    output in_ready, out_valid, sum, carry, overflow, eq, lt, ltu
  );
endinterface

// File: rtl/adder_serial.sv
// Digit-serial add/subtract with comparator flags: N-bit operands processed
// D bits per clock, LSB digit first, carry held in a register between digits.
module adder_serial #(
  parameter int N = 16,
  parameter int D = 4
) (
  input logic           clk,
  input logic           rst_n,
  adder_serial_if.slave bus
);
  localparam int K  = N / D;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if ((N % D) != 0 || D > N) begin : g_bad_params
    $error("adder_serial: D must divide N and not exceed it");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_x;
  logic [N-1:0]   r_y;
  logic           r_sub;
  logic           r_c;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_acc;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_ovf;
  logic           r_eq;
  logic           r_lt;
  logic           r_ltu;

  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_last;
  logic [D-1:0]   w_yd;
  logic [D:0]     w_dsum;
  logic [N-1:0]   w_acc_nxt;
  logic           w_cout;
  logic           w_cnm1;
  logic           w_ovf;
  logic           w_eq;

  assign w_last = (r_cnt == CW'(K - 1));

  // Operands shift right each digit so the active digit is always bits [D-1:0];
  // the result digit enters at the top of the accumulator.
  always_comb begin
    w_yd      = r_y[D-1:0] ^ {D{r_sub}};
    w_dsum    = {1'b0, r_x[D-1:0]} + {1'b0, w_yd} + {{D{1'b0}}, r_c};
    w_cout    = w_dsum[D];
    w_acc_nxt = (r_acc >> D) | (N'(w_dsum[D-1:0]) << (N - D));
    // Carry into the top bit recovered from that bit's inputs and sum.
    w_cnm1    = r_x[D-1] ^ w_yd[D-1] ^ w_dsum[D-1];
    w_ovf     = w_cnm1 ^ w_cout;
    w_eq      = r_sub & (w_acc_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = rst_n & (r_state == S_IDLE);
    w_out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_sub   <= 1'b0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_ltu   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.in_valid) begin
        r_x   <= bus.X;
        r_y   <= bus.Y;
        r_sub <= bus.Nadd_sub;
        r_c   <= bus.Nadd_sub;
        r_cnt <= '0;
        r_acc <= '0;
      end else if (r_state == S_RUN) begin
        r_x   <= r_x >> D;
        r_y   <= r_y >> D;
        r_c   <= w_cout;
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum   <= w_acc_nxt;
          r_carry <= w_cout;
          r_ovf   <= w_ovf;
          r_eq    <= w_eq;
          r_lt    <= r_sub & ~w_eq & (w_acc_nxt[N-1] ^ w_ovf);
          r_ltu   <= r_sub & ~w_eq & ~w_cout;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
  assign bus.ltu       = r_ltu;
endmodule

// File: tb/tb_adder_serial.sv
// Directed bench for adder_serial: N=8 with D=2 (K=4) and D=8 (K=1).
module tb_adder_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_serial_if #(.N(8)) bus_d2 ();
  adder_serial_if #(.N(8)) bus_d8 ();

  adder_serial #(.N(8), .D(2)) u_dut_d2 (.clk(clk), .rst_n(rst_n), .bus(bus_d2));
  adder_serial #(.N(8), .D(8)) u_dut_d8 (.clk(clk), .rst_n(rst_n), .bus(bus_d8));

  // sel picks which DUT the stimulus drives and whose outputs are observed.
  logic       sel;
  logic       iv, ordy, sub;
  logic [7:0] xd, yd;

  assign bus_d2.in_valid  = iv & ~sel;
  assign bus_d8.in_valid  = iv & sel;
  assign bus_d2.out_ready = ordy & ~sel;
  assign bus_d8.out_ready = ordy & sel;
  assign bus_d2.Nadd_sub  = sub;
  assign bus_d8.Nadd_sub  = sub;
  assign bus_d2.X = xd;
  assign bus_d8.X = xd;
  assign bus_d2.Y = yd;
  assign bus_d8.Y = yd;

  logic       o_rdy, o_vld, o_c, o_ov, o_eq, o_lt, o_ltu;
  logic [7:0] o_sum;
  always_comb begin
    o_rdy = sel ? bus_d8.in_ready  : bus_d2.in_ready;
    o_vld = sel ? bus_d8.out_valid : bus_d2.out_valid;
    o_sum = sel ? bus_d8.sum       : bus_d2.sum;
    o_c   = sel ? bus_d8.carry     : bus_d2.carry;
    o_ov  = sel ? bus_d8.overflow  : bus_d2.overflow;
    o_eq  = sel ? bus_d8.eq        : bus_d2.eq;
    o_lt  = sel ? bus_d8.lt        : bus_d2.lt;
    o_ltu = sel ? bus_d8.ltu       : bus_d2.ltu;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [7:0] e_sum,
                              input logic e_c, e_o, e_eq, e_lt, e_ltu);
    chk({tag, ".sum"}, 32'(o_sum), 32'(e_sum));
    chk({tag, ".flags"}, {26'd0, o_vld, o_c, o_ov, o_eq, o_lt, o_ltu},
        {26'd0, 1'b1, e_c, e_o, e_eq, e_lt, e_ltu});
  endtask

  // Accept at the next edge, then count edges until out_valid is seen.
  task automatic start_op(input string tag, input logic s, input logic [7:0] x, y,
                          input int exp_lat);
    int lat;
    chk({tag, ".in_ready"}, 32'(o_rdy), 32'd1);
    sub = s; xd = x; yd = y; iv = 1'b1;
    tick();
    iv = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_vld) break;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic finish_op(input string tag);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk({tag, ".ready_after"}, {30'd0, o_rdy, o_vld}, {30'd0, 1'b1, 1'b0});
  endtask

  task automatic do_op(input string tag, input logic s, input logic [7:0] x, y,
                       input int exp_lat, input logic [7:0] e_sum,
                       input logic e_c, e_o, e_eq, e_lt, e_ltu);
    start_op(tag, s, x, y, exp_lat);
    check_result(tag, e_sum, e_c, e_o, e_eq, e_lt, e_ltu);
    finish_op(tag);
  endtask

  initial begin
    sel = 1'b0; iv = 1'b0; ordy = 1'b0; sub = 1'b0; xd = '0; yd = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset.state", {22'd0, o_rdy, o_vld, o_sum}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("reset.release_ready", 32'(o_rdy), 32'd1);

    do_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 4, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_05_05", 1'b1, 8'h05, 8'h05, 4, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("sub_03_05", 1'b1, 8'h03, 8'h05, 4, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure: result must hold and a fresh in_valid must be ignored.
    start_op("bp", 1'b1, 8'h80, 8'h01, 4);
    check_result("bp.first", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    sub = 1'b0; xd = 8'hAA; yd = 8'h55; iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_result("bp.hold", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("bp.in_ready_low", 32'(o_rdy), 32'd0);
    end
    iv = 1'b0;
    finish_op("bp");
    tick(); tick();
    chk("bp.no_spurious", {23'd0, o_vld, o_sum}, {23'd0, 1'b0, 8'h7F});

    // Reset during digit 2 of a D=2 run.
    chk("rst_mid.in_ready", 32'(o_rdy), 32'd1);
    sub = 1'b1; xd = 8'h44; yd = 8'h11; iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid.cleared", {22'd0, o_rdy, o_vld, o_sum}, 32'd0);
    chk("rst_mid.flags", {27'd0, o_c, o_ov, o_eq, o_lt, o_ltu}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid.release_ready", 32'(o_rdy), 32'd1);
    do_op("sub_10_20", 1'b1, 8'h10, 8'h20, 4, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Single-digit configuration.
    sel = 1'b1;
    #1;
    do_op("d8_add_7f_01", 1'b0, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("d8_sub_05_05", 1'b1, 8'h05, 8'h05, 1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adder_serial.md
# adder_serial

Digit-serial, parametrised successor to the combinational adder/comparator. It adds or subtracts two N-bit operands D bits per clock, LSB digit first, keeping the carry in a register between digits. It produces the same result and flag set as the combinational block: sum, carry, overflow, eq, lt, ltu. It sits in datapaths where a full-width ripple or fast adder is too costly in area, behind a valid/ready handshake on both sides.

## Interface
- N, default 16: operand width in bits.
- D, default 4: digit width, i.e. bits processed per cycle. N % D != 0 or D > N is an elaboration error. D == N is legal and gives a one-digit run.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operands and mode are present.
- in_ready  out  1  block can accept an operation.
- Nadd_sub  in  1  mode select: 0 = addition, 1 = subtraction (X − Y).
- X  in  N  first operand.
- Y  in  N  second operand.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  X + Y, or X + ~Y + 1, modulo 2^N.
- carry  out  1  final carry-out C[N]. In subtract mode, 1 means no borrow.
- overflow  out  1  C[N−1] ^ C[N].
- eq  out  1  Nadd_sub & (sum == 0).
- lt  out  1  signed less-than: Nadd_sub & ~eq & (sum[N−1] ^ overflow).
- ltu  out  1  unsigned less-than: Nadd_sub & ~eq & ~carry.

## Operation
- K = N/D digits per operation. Digit counter width is clog2(K), minimum 1.
- State machine IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch X, Y and Nadd_sub, load carry register with Nadd_sub, clear the digit counter, go to RUN.
- RUN:
  - Per cycle, digit i = X[iD+D−1:iD] + (Y digit ^ {D{Nadd_sub}}) + carry register.
  - Write the D-bit result into sum[iD+D−1:iD]; store the carry-out in the carry register.
  - On the last digit (i = K−1), also capture the carry into the MSB position of that digit as C[N−1] for overflow.
  - After the last digit, register all flags and go to DONE.
- DONE:
  - out_valid = 1; sum and flags are stable.
  - On out_valid & out_ready, go to IDLE.
- In add mode, eq/lt/ltu are forced to 0.
- in_ready = 0 in RUN and DONE. in_valid is ignored there; the operand registers do not change.
- sum and flags hold the last completed result until the next operation completes. Partially written sum bits during RUN are not architecturally visible, because out_valid = 0.
- Reset (rst_n = 0 at a rising edge), including mid-RUN or in DONE:
  - State goes to IDLE.
  - sum, carry, overflow, eq, lt, ltu, out_valid, the counter and the carry register all go to 0.
  - In-flight work is discarded.
  - in_ready is 0 while rst_n is low and 1 from the first cycle after release.

## Timing
- Acceptance edge E0: in_valid & in_ready sampled high.
- Digit i is computed in the cycle after edge E_i and registered at E_{i+1}.
- out_valid rises in the cycle after E_K, i.e. latency is K cycles from acceptance to out_valid. For D = N, latency is 1.
- out_valid stays high with stable outputs for any number of out_ready-low cycles.
- Minimum issue interval is K + 2 cycles: RUN K, DONE ≥1, IDLE 1. There is no accept in the same cycle as the output handshake.
- Combinational paths are limited to one D-bit digit adder plus flag logic. There is no path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
Bench uses N = 8, D = 2, so K = 4.
- Add 0x7F + 0x01 → out_valid 4 cycles after acceptance; sum 0x80, carry 0, overflow 1, eq/lt/ltu 0.
- Add 0xFF + 0x01 → sum 0x00, carry 1, overflow 0, eq 0 (add mode).
- Sub 0x05 − 0x05 → sum 0x00, carry 1, eq 1, lt 0, ltu 0.
- Sub 0x03 − 0x05 → sum 0xFE, carry 0, overflow 0, lt 1, ltu 1. Then sub 0x80 − 0x01 → sum 0x7F, carry 1, overflow 1, lt 1, ltu 0.
- Backpressure:
  - Hold out_ready low for 5 cycles after out_valid; sum and flags must stay constant, in_ready must stay 0, and a new in_valid must be ignored.
  - Then raise out_ready for one cycle; the block returns to IDLE with in_ready = 1 the following cycle.
- Reset mid-RUN: drop rst_n during digit 2.
  - Next cycle: out_valid 0, sum 0x00, all flags 0.
  - After release: in_ready 1.
  - A subsequent sub 0x10 − 0x20 must give sum 0xF0, lt 1, ltu 1.
- Repeat the first and third scenarios with D = 8 (K = 1): latency 1, same results.
